interval_meter: RTL and testbench
=================================

INTERVAL_METER -- requirements
Module: interval_meter

Interface
REQ-001: Parameter TIMEOUT [20:0], default 21'h1F_FFFF; maximum measurable interval in cycles; must be >= 1.
REQ-002: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003: RST_N  input  1  reset, asynchronous, active-low.
REQ-004: CLR  input  1  synchronous clear; abandons any measurement.
REQ-005: START  input  1  single-cycle level; begins an interval when sampled high in IDLE.
REQ-006: STOP  input  1  single-cycle level; ends the interval when sampled high in MEASURE.
REQ-007: COUNT  output  21  last measured interval in cycles; held until next completion.
REQ-008: VALID  output  1  one-cycle pulse: COUNT updated by a STOP.
REQ-009: OVF  output  1  one-cycle pulse: interval reached TIMEOUT without STOP.
REQ-010: BUSY  output  1  high while in MEASURE state.
REQ-011: MIN_CNT  output  21  smallest VALID COUNT since reset/CLR (stats feature).
REQ-012: MAX_CNT  output  21  largest VALID COUNT since reset/CLR (stats feature).

Function
REQ-013: SHALL implement two states, IDLE (encoding 0) and MEASURE (1); unused encodings return to IDLE next cycle.
REQ-014: IDLE: START=1 SHALL go to MEASURE with internal counter loaded to 1; STOP ignored, including when simultaneous with START.
REQ-015: MEASURE: START SHALL be ignored (no restart).
REQ-016: MEASURE, STOP=1: COUNT <= counter, VALID pulses next cycle, state -> IDLE; START at cycle t, STOP at cycle t+n SHALL give COUNT=n.
REQ-017: MEASURE, STOP=0, counter==TIMEOUT: COUNT <= TIMEOUT, OVF pulses, state -> IDLE, VALID stays 0.
REQ-018: MEASURE, STOP=0, counter<TIMEOUT: counter SHALL increment by 1; counter never exceeds TIMEOUT, no wrap.
REQ-019: STOP and timeout in the same cycle: STOP SHALL win (VALID, COUNT=TIMEOUT, no OVF).
REQ-020: VALID and OVF SHALL never be high together and each SHALL be high at most one cycle per interval.
REQ-021: START sampled in the cycle after VALID/OVF (state IDLE) SHALL be accepted; back-to-back intervals lose no cycles.
REQ-022: BUSY SHALL be high exactly in cycles where state is MEASURE (registered, one cycle after START).
REQ-023: CLR SHALL have priority over START/STOP: state IDLE, counter 0, COUNT 0, VALID 0, OVF 0, stats reinitialised.

Reset
REQ-024: RST_N low SHALL asynchronously force state IDLE, counter 0, COUNT 0, VALID 0, OVF 0, BUSY 0, MIN_CNT 21'h1F_FFFF, MAX_CNT 0.
REQ-025: Reset asserted mid-MEASURE SHALL discard the interval with no VALID or OVF after release.
REQ-026: After RST_N deasserts, the first edge SHALL behave as IDLE.

Configuration
REQ-027: Macro INTERVAL_METER_STATS_EN defined: on each VALID, MIN_CNT <= min(MIN_CNT, COUNT value), MAX_CNT <= max(MAX_CNT, COUNT value), updated same edge as COUNT; OVF events excluded.
REQ-028: Macro undefined: MIN_CNT and MAX_CNT ports SHALL exist and be constant 0; no stats registers synthesised.

Verification (TIMEOUT=21'h00_0010 unless stated)
REQ-029: Reset, START at t, STOP at t+5 -> COUNT=5, VALID one cycle, BUSY high t+1..t+5, OVF 0.
REQ-030: START, no STOP -> OVF one cycle 16 cycles after START, COUNT=16, VALID 0, BUSY falls with OVF.
REQ-031: STOP exactly at t+16 -> VALID, COUNT=16, OVF 0; START+STOP same cycle in IDLE -> MEASURE entered, later STOP at +3 gives COUNT=3.
REQ-032: CLR at t+3 of interval, then START/STOP +2 -> no VALID for first, second COUNT=2; RST_N low mid-interval -> all outputs at reset values, no pulse after release.
REQ-033: STATS_EN: intervals 7, 3, 9 back-to-back (START cycle after VALID) -> MIN_CNT=3, MAX_CNT=9; a following OVF leaves both unchanged; without macro both read 0.
REQ-034: STOP in IDLE and START in MEASURE (at +2, STOP at +4) -> no effect; COUNT=4.

Source files
------------

// File: rtl/interval_meter.sv
// interval_meter: measures the number of clock cycles between a START
// pulse and the following STOP pulse, with an overflow timeout.
//
// Optional feature: define INTERVAL_METER_STATS_EN to keep running
// min/max statistics of valid measurements. When it is undefined, MIN_CNT
// and MAX_CNT are tied to 0 and no statistics registers exist.
//
// Ports:
//   CLK      in   sole clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   CLR      in   synchronous clear, abandons any measurement
//   START    in   begins an interval when sampled high in IDLE
//   STOP     in   ends an interval when sampled high in MEASURE
//   COUNT    out  [20:0] last measured interval, held until next completion
//   VALID    out  one-cycle pulse, COUNT updated by a STOP
//   OVF      out  one-cycle pulse, interval reached TIMEOUT without STOP
//   BUSY     out  high while measuring
//   MIN_CNT  out  [20:0] smallest valid COUNT since reset/CLR
//   MAX_CNT  out  [20:0] largest valid COUNT since reset/CLR
//
// state   | meaning
// IDLE    | waiting for START; STOP ignored
// MEASURE | counting cycles; START ignored, STOP or timeout ends it
module interval_meter #(
  parameter logic [20:0] TIMEOUT = 21'h1F_FFFF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CLR,
  input  logic        START,
  input  logic        STOP,
  output logic [20:0] COUNT,
  output logic        VALID,
  output logic        OVF,
  output logic        BUSY,
  output logic [20:0] MIN_CNT,
  output logic [20:0] MAX_CNT
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [20:0] cnt_q, cnt_d;
  logic [20:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    valid_d = 1'b0;
    ovf_d   = 1'b0;
    if (CLR) begin
      state_d = IDLE;
      cnt_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // counter starts at 1 so STOP n cycles after START reports n
          if (START) begin
            state_d = MEASURE;
            cnt_d   = 21'd1;
          end
        end
        MEASURE: begin
          // STOP takes precedence over a coincident timeout
          if (STOP) begin
            state_d = IDLE;
            count_d = cnt_q;
            valid_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q >= TIMEOUT) begin
            state_d = IDLE;
            count_d = TIMEOUT;
            ovf_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 21'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign COUNT = count_q;
  assign VALID = valid_q;
  assign OVF   = ovf_q;
  assign BUSY  = (state_q == MEASURE);

`ifdef INTERVAL_METER_STATS_EN
  logic [20:0] min_q, max_q;

  // updated on the same edge that loads COUNT from a STOP
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      min_q <= 21'h1F_FFFF;
      max_q <= '0;
    end else if (CLR) begin
      min_q <= 21'h1F_FFFF;
      max_q <= '0;
    end else if (valid_d) begin
      if (count_d < min_q) min_q <= count_d;
      if (count_d > max_q) max_q <= count_d;
    end
  end

  assign MIN_CNT = min_q;
  assign MAX_CNT = max_q;
`else
  assign MIN_CNT = '0;
  assign MAX_CNT = '0;
`endif

endmodule

// File: tb/tb_interval_meter.sv
module tb_interval_meter;

  localparam logic [20:0] TO = 21'h00_0010;
`ifdef INTERVAL_METER_STATS_EN
  localparam logic [20:0] MIN_RST = 21'h1F_FFFF;
  localparam logic [20:0] EXP_MIN = 21'd3;
  localparam logic [20:0] EXP_MAX = 21'd9;
`else
  localparam logic [20:0] MIN_RST = 21'd0;
  localparam logic [20:0] EXP_MIN = 21'd0;
  localparam logic [20:0] EXP_MAX = 21'd0;
`endif

  logic        CLK, RST_N, CLR, START, STOP;
  logic [20:0] COUNT, MIN_CNT, MAX_CNT;
  logic        VALID, OVF, BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          ovf;
    logic [20:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  interval_meter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .START(START), .STOP(STOP),
    .COUNT(COUNT), .VALID(VALID), .OVF(OVF), .BUSY(BUSY),
    .MIN_CNT(MIN_CNT), .MAX_CNT(MAX_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push(input bit ovf, input logic [20:0] cnt);
    exp_t e;
    e.ovf = ovf;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // START sampled at edge t, STOP sampled at edge t+n; BUSY checked each cycle
  task automatic interval(input int n);
    push(1'b0, 21'(n));
    START = 1'b1;
    tick(1);
    START = 1'b0;
    for (int i = 1; i < n; i++) begin
      check("busy_in", BUSY, 1);
      tick(1);
    end
    check("busy_last", BUSY, 1);
    STOP = 1'b1;
    tick(1);
    STOP = 1'b0;
    check("busy_after", BUSY, 0);
  endtask

  task automatic timeout_run();
    push(1'b1, TO);
    START = 1'b1;
    tick(1);
    START = 1'b0;
    tick(15);
    check("busy_pre_ovf", BUSY, 1);
    tick(1);
    check("busy_at_ovf", BUSY, 0);
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a pulse
  always @(negedge CLK) begin
    if (RST_N && (VALID || OVF)) begin
      exp_t e;
      check("valid_ovf_excl", {31'd0, VALID & OVF}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got VALID=%0b OVF=%0b COUNT=%0d expected none at %0t",
                 VALID, OVF, COUNT, $time);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_ovf", {31'd0, OVF}, {31'd0, e.ovf});
        check("pulse_count", {11'd0, COUNT}, {11'd0, e.cnt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; CLR = 1'b0; START = 1'b0; STOP = 1'b0;
    tick(2);
    check("rst_count", COUNT, 0);
    check("rst_valid", VALID, 0);
    check("rst_ovf", OVF, 0);
    check("rst_busy", BUSY, 0);
    check("rst_min", MIN_CNT, MIN_RST);
    check("rst_max", MAX_CNT, 0);
    RST_N = 1'b1;
    tick(1);

    // STOP alone in IDLE does nothing
    STOP = 1'b1;
    tick(1);
    STOP = 1'b0;
    check("stop_idle_busy", BUSY, 0);
    tick(2);

    interval(5);
    timeout_run();
    interval(16);

    // START and STOP together in IDLE: enter MEASURE, STOP at +3
    push(1'b0, 21'd3);
    START = 1'b1; STOP = 1'b1;
    tick(1);
    START = 1'b0; STOP = 1'b0;
    check("ss_busy", BUSY, 1);
    tick(2);
    STOP = 1'b1;
    tick(1);
    STOP = 1'b0;
    tick(1);

    // START in MEASURE ignored: START at +2, STOP at +4
    push(1'b0, 21'd4);
    START = 1'b1; tick(1);
    START = 1'b0; tick(1);
    START = 1'b1; tick(1);
    START = 1'b0; tick(1);
    STOP = 1'b1;  tick(1);
    STOP = 1'b0;
    tick(1);

    // CLR at +3 abandons the interval, next interval of 2
    START = 1'b1; tick(1);
    START = 1'b0; tick(2);
    CLR = 1'b1; tick(1);
    CLR = 1'b0;
    check("clr_busy", BUSY, 0);
    check("clr_count", COUNT, 0);
    check("clr_min", MIN_CNT, MIN_RST);
    check("clr_max", MAX_CNT, 0);
    interval(2);
    tick(1);

    // reset mid-interval discards it
    START = 1'b1; tick(1);
    START = 1'b0; tick(2);
    RST_N = 1'b0;
    #1;
    check("mrst_busy", BUSY, 0);
    check("mrst_count", COUNT, 0);
    check("mrst_valid", VALID, 0);
    check("mrst_ovf", OVF, 0);
    check("mrst_min", MIN_CNT, MIN_RST);
    check("mrst_max", MAX_CNT, 0);
    tick(2);
    RST_N = 1'b1;
    tick(20);
    check("post_rst_busy", BUSY, 0);

    // stats: 7, 3, 9 back-to-back, then an overflow
    interval(7);
    interval(3);
    interval(9);
    check("stats_min", MIN_CNT, EXP_MIN);
    check("stats_max", MAX_CNT, EXP_MAX);
    check("stats_count", COUNT, 9);
    timeout_run();
    tick(1);
    check("ovf_min", MIN_CNT, EXP_MIN);
    check("ovf_max", MAX_CNT, EXP_MAX);
    check("ovf_count", COUNT, TO);

    tick(3);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
